// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and a
// multi-cycle (MUL/DIV) stall FSM. Define HAZARD_PERF_EN to build the perf counters.
module hazard_unit_mc #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_D,
    input  logic [REG_AW-1:0] rs2_D,
    input  logic [REG_AW-1:0] rs1_E,
    input  logic [REG_AW-1:0] rs2_E,
    input  logic [REG_AW-1:0] rd_E,
    input  logic [REG_AW-1:0] rd_M,
    input  logic [REG_AW-1:0] rd_W,
    input  logic              regwrite_M,
    input  logic              regwrite_W,
    input  logic              memtoreg_E,
    input  logic              mc_start_E,
    input  logic              branch_taken_E,
    input  logic              perf_clr,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    localparam logic [7:0] MC_LOAD = 8'(MC_LAT - 1);

    mc_state_t  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       lu;
    logic       mc_stall;
    logic       br_flush;

    always_comb begin
        ForwardAE = 2'b00;
        if (regwrite_M && (rd_M != '0) && (rd_M == rs1_E))
            ForwardAE = 2'b10;
        else if (regwrite_W && (rd_W != '0) && (rd_W == rs1_E))
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (regwrite_M && (rd_M != '0) && (rd_M == rs2_E))
            ForwardBE = 2'b10;
        else if (regwrite_W && (rd_W != '0) && (rd_W == rs2_E))
            ForwardBE = 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mc_start_E) begin
                    state_d = BUSY;
                    cnt_d   = MC_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd1)
                    state_d = DONE;
                else
                    cnt_d = cnt_q - 8'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All hazard controls are gated by rst_n so that an asserted reset drops
    // them in the same cycle, even while mc_start_E or a load-use is present.
    always_comb begin
        lu       = rst_n && memtoreg_E && (rd_E != '0) &&
                   ((rd_E == rs1_D) || (rd_E == rs2_D));
        mc_stall = rst_n && (((state_q == IDLE) && mc_start_E) || (state_q == BUSY));
        br_flush = rst_n && branch_taken_E && !mc_stall;

        StallF  = mc_stall || (lu && !br_flush);
        StallD  = mc_stall || (lu && !br_flush);
        StallE  = mc_stall;
        FlushM  = mc_stall;
        FlushD  = br_flush;
        FlushE  = !mc_stall && (lu || br_flush);
        mc_busy = rst_n && (state_q == BUSY);
        mc_done = rst_n && (state_q == DONE);
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (perf_clr) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (StallF && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if ((FlushD || FlushE) && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    logic unused_perf_clr;

    assign unused_perf_clr = perf_clr;
    assign stall_cnt       = '0;
    assign flush_cnt       = '0;
`endif

endmodule

// File: doc/hazard_unit_mc.md
HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  REG_AW  5  register-address width
  MC_LAT  4  stall cycles per multi-cycle op, legal 2..255
  CNT_W  32  performance-counter width
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  reset, asynchronous, active-low
  rs1_D, rs2_D  in  REG_AW  source regs in Decode
  rs1_E, rs2_E, rd_E  in  REG_AW  source/dest regs in Execute
  rd_M, rd_W  in  REG_AW  dest regs in Memory/Writeback
  regwrite_M, regwrite_W  in  1  stage writes its rd
  memtoreg_E  in  1  load in Execute
  mc_start_E  in  1  multi-cycle op (MUL/DIV) valid in Execute
  branch_taken_E  in  1  taken branch/jump resolved in Execute
  perf_clr  in  1  synchronous clear of perf counters
  StallF, StallD, StallE  out  1  hold PC / IF-ID / ID-EX
  FlushD, FlushE, FlushM  out  1  bubble into IF-ID / ID-EX / EX-MEM
  ForwardAE, ForwardBE  out  2  ALU operand A / B mux select
  mc_busy  out  1  FSM in BUSY
  mc_done  out  1  one-cycle pulse, FSM in DONE
  stall_cnt, flush_cnt  out  CNT_W  performance counters

Function
REQ-003 ForwardAE SHALL be combinational: 2'b10 if regwrite_M && rd_M!=0 && rd_M==rs1_E; else 2'b01 if regwrite_W && rd_W!=0 && rd_W==rs1_E; else 2'b00 (M priority over W).
REQ-004 ForwardBE SHALL follow REQ-003 with rs2_E in place of rs1_E.
REQ-005 lu = memtoreg_E && rd_E!=0 && (rd_E==rs1_D || rd_E==rs2_D); lu SHALL assert StallF, StallD, FlushE in the same cycle.
REQ-006 Multi-cycle FSM SHALL have states IDLE, BUSY, DONE and an 8-bit down-counter cnt.
REQ-007 IDLE: mc_start_E -> BUSY with cnt<=MC_LAT-1; else stay; mc_start_E SHALL be ignored in BUSY and DONE.
REQ-008 BUSY: cnt==1 -> DONE; else cnt<=cnt-1.
REQ-009 DONE SHALL go to IDLE unconditionally; mc_done=1 only in DONE; mc_busy=1 only in BUSY.
REQ-010 mc_stall = (IDLE && mc_start_E) || BUSY SHALL assert StallF, StallD, StallE, FlushM: exactly MC_LAT stall cycles per op; op leaves Execute on the edge ending DONE.
REQ-011 mc_stall SHALL override lu: FlushE=0 while mc_stall (ID-EX held, not flushed).
REQ-012 branch_taken_E && !mc_stall SHALL assert FlushD and FlushE and SHALL force StallF=StallD=0 (wrong-path load-use discarded).
REQ-013 FlushM SHALL equal mc_stall; no other source drives FlushM or StallE.

Reset
REQ-014 rst_n low SHALL asynchronously force state IDLE, cnt=0, counters=0.
REQ-015 While rst_n low, all Stall*/Flush* outputs, mc_busy, mc_done SHALL be 0; ForwardAE/BE remain combinational.
REQ-016 Reset during BUSY SHALL abort the op: stalls drop immediately, no mc_done pulse, IDLE on release.

Configuration
REQ-017 Macro HAZARD_PERF_EN defined: stall_cnt +1 each cycle StallF=1, flush_cnt +1 each cycle FlushD||FlushE=1; both saturate at all-ones; perf_clr zeroes both next edge, clear wins over increment.
REQ-018 HAZARD_PERF_EN undefined: no counter flops; stall_cnt, flush_cnt tied 0; perf_clr ignored; ports retained.

Verification
REQ-019 regwrite_M=regwrite_W=1, rd_M=rd_W=5, rs1_E=5, rs2_E=3 -> ForwardAE=10, ForwardBE=00; then rd_M=0 -> ForwardAE=01.
REQ-020 memtoreg_E=1, rd_E=7, rs2_D=7 -> StallF=StallD=FlushE=1; rd_E=0 -> all three 0.
REQ-021 MC_LAT=4, mc_start_E high 5 cycles from IDLE -> StallE=FlushM=1 cycles 1-4, mc_done=1 cycle 5, IDLE cycle 6.
REQ-022 branch_taken_E=1 with lu=1 in IDLE -> FlushD=FlushE=1, StallF=StallD=0; same during BUSY -> FlushD=FlushE=0, StallE=1.
REQ-023 rst_n low in 2nd BUSY cycle -> StallE=0 same cycle, no mc_done, mc_start_E=0 after release keeps IDLE.
REQ-024 HAZARD_PERF_EN, CNT_W=4: 20 load-use cycles -> stall_cnt=15 (saturated); perf_clr=1 one cycle -> stall_cnt=0.
